// File: rtl/frame_ones_accumulator.sv
// Counts the 1 bits of each accepted word and accumulates them over an in_last-delimited frame.
// The frame total and word count are held on a valid/ready output until the consumer takes them.
module frame_ones_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_vector,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] total_count,
    output logic [ACC_WIDTH-1:0] word_count,
    output logic                 saturated
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc_total;
    logic [ACC_WIDTH-1:0] acc_words;
    logic                 sat_flag;

    logic [CW-1:0]        ones;
    logic [ACC_WIDTH:0]   sum_total;
    logic [ACC_WIDTH:0]   sum_words;
    logic [ACC_WIDTH-1:0] next_total;
    logic [ACC_WIDTH-1:0] next_words;
    logic                 clip;
    logic                 accept;

    // Gated by rst so upstream never sees a handshake that reset is about to discard.
    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(in_vector[i]);
        end
    end

    // One guard bit suffices: both operands are at most 2^ACC_WIDTH - 1, so the carry flags a clip.
    always_comb begin
        sum_total  = {1'b0, acc_total} + (ACC_WIDTH + 1)'(ones);
        sum_words  = {1'b0, acc_words} + (ACC_WIDTH + 1)'(1);
        next_total = sum_total[ACC_WIDTH] ? '1 : sum_total[ACC_WIDTH-1:0];
        next_words = sum_words[ACC_WIDTH] ? '1 : sum_words[ACC_WIDTH-1:0];
        clip       = sum_total[ACC_WIDTH] | sum_words[ACC_WIDTH];
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc_total   <= '0;
            acc_words   <= '0;
            sat_flag    <= 1'b0;
            out_valid   <= 1'b0;
            total_count <= '0;
            word_count  <= '0;
            saturated   <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                if (in_last) begin
                    total_count <= next_total;
                    word_count  <= next_words;
                    saturated   <= sat_flag | clip;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end else begin
                    acc_total <= next_total;
                    acc_words <= next_words;
                    sat_flag  <= sat_flag | clip;
                end
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
                acc_total <= '0;
                acc_words <= '0;
                sat_flag  <= 1'b0;
                state     <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_frame_ones_accumulator.sv
// Bench for frame_ones_accumulator: directed scenarios plus random frames against a sum-of-popcounts model.
// Two instances share stimulus: ACC_WIDTH=16 (sel=0) and ACC_WIDTH=4 (sel=1) for saturation.
module tb_frame_ones_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vector;
    logic       in_last;
    logic       out_ready;
    logic       sel;

    logic        a_in_ready, a_out_valid, a_saturated;
    logic [15:0] a_total, a_words;
    logic        b_in_ready, b_out_valid, b_saturated;
    logic [3:0]  b_total, b_words;

    logic        o_in_ready, o_out_valid, o_saturated;
    logic [15:0] o_total, o_words;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    frame_ones_accumulator #(.WIDTH(8), .ACC_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_vector(in_vector), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .total_count(a_total), .word_count(a_words), .saturated(a_saturated)
    );

    frame_ones_accumulator #(.WIDTH(8), .ACC_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_vector(in_vector), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .total_count(b_total), .word_count(b_words), .saturated(b_saturated)
    );

    always_comb begin
        o_in_ready  = sel ? b_in_ready  : a_in_ready;
        o_out_valid = sel ? b_out_valid : a_out_valid;
        o_saturated = sel ? b_saturated : a_saturated;
        o_total     = sel ? {12'd0, b_total} : a_total;
        o_words     = sel ? {12'd0, b_words} : a_words;
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Presents one beat and returns at the falling edge after it is accepted; in_valid stays high.
    task automatic send(input logic [7:0] v, input logic l);
        in_vector = v;
        in_last   = l;
        in_valid  = 1'b1;
        #1;
        for (int t = 0; t < 20 && !o_in_ready; t++) begin
            @(negedge clk);
            #1;
        end
        check(32'(o_in_ready), 1, "send_ready");
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the falling edge after the last beat; holds the result for 'hold' cycles, then accepts it.
    task automatic check_result(input int tot, input int wds, input logic s, input int hold, input string tag);
        #1;
        check(32'(o_out_valid), 1, {tag, "_valid"});
        check(32'(o_total), 32'(tot), {tag, "_total"});
        check(32'(o_words), 32'(wds), {tag, "_words"});
        check(32'(o_saturated), 32'(s), {tag, "_sat"});
        check(32'(o_in_ready), 0, {tag, "_ready_low"});
        out_ready = (hold == 0);
        repeat (hold) begin
            @(negedge clk);
            check(32'(o_out_valid), 1, {tag, "_hold_valid"});
            check(32'(o_total), 32'(tot), {tag, "_hold_total"});
            check(32'(o_words), 32'(wds), {tag, "_hold_words"});
            check(32'(o_in_ready), 0, {tag, "_hold_ready"});
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check(32'(o_out_valid), 0, {tag, "_drop"});
        check(32'(o_in_ready), 1, {tag, "_ready_back"});
        check(32'(o_total), 32'(tot), {tag, "_kept_total"});
    endtask

    initial begin
        logic [7:0] w;
        int len, raw, gap, mx;

        rst = 1'b1; in_valid = 1'b0; in_vector = '0; in_last = 1'b0; out_ready = 1'b1; sel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check(32'(o_in_ready), 0, "rst_ready");
        check(32'(o_out_valid), 0, "rst_valid");
        check(32'(o_total), 0, "rst_total");
        check(32'(o_words), 0, "rst_words");
        check(32'(o_saturated), 0, "rst_sat");
        rst = 1'b0;
        #1;
        check(32'(o_in_ready), 1, "rst_release_ready");

        // Six-word frame: 0+8+4+4+4+2 ones.
        send(8'h00, 0); send(8'hFF, 0); send(8'hAA, 0);
        send(8'hF0, 0); send(8'h0F, 0); send(8'h81, 1);
        in_valid = 1'b0;
        check_result(22, 6, 0, 0, "six");

        send(8'hFF, 1);
        in_valid = 1'b0;
        check_result(8, 1, 0, 0, "single");

        send(8'h01, 0); in_valid = 1'b0; repeat (2) @(negedge clk);
        send(8'h03, 0); in_valid = 1'b0; repeat (2) @(negedge clk);
        send(8'h07, 1); in_valid = 1'b0;
        check_result(6, 3, 0, 0, "gaps");

        // Backpressure: FF waits through HOLD and must be consumed exactly once afterwards.
        send(8'hF0, 0);
        send(8'h0F, 1);
        in_vector = 8'hFF; in_last = 1'b0; in_valid = 1'b1;
        check_result(8, 2, 0, 5, "bp");
        send(8'hFF, 0);
        send(8'h01, 1);
        in_valid = 1'b0;
        check_result(9, 2, 0, 0, "bp_next");

        sel = 1'b1;
        send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 1);
        in_valid = 1'b0;
        check_result(15, 3, 1, 0, "satur");
        send(8'h03, 1);
        in_valid = 1'b0;
        check_result(2, 1, 0, 0, "satur_next");
        sel = 1'b0;

        send(8'hFF, 0); send(8'hFF, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check(32'(o_in_ready), 0, "midrst_ready");
        @(negedge clk);
        rst = 1'b0;
        send(8'h0F, 1);
        in_valid = 1'b0;
        check_result(4, 1, 0, 0, "midrst");

        send(8'h0F, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check(32'(o_out_valid), 1, "holdrst_pre");
        rst = 1'b1;
        @(negedge clk);
        #1;
        check(32'(o_out_valid), 0, "holdrst_valid");
        check(32'(o_total), 0, "holdrst_total");
        check(32'(o_words), 0, "holdrst_words");
        rst = 1'b0;
        #1;
        check(32'(o_in_ready), 1, "holdrst_ready");
        out_ready = 1'b1;

        // Random frames: expected total is the plain sum of popcounts, clipped to the counter range.
        for (int f = 0; f < 40; f++) begin
            @(negedge clk);
            sel = 1'($urandom_range(0, 1));
            len = $urandom_range(1, sel ? 6 : 10);
            raw = 0;
            for (int k = 0; k < len; k++) begin
                w = 8'($urandom);
                raw += $countones(w);
                send(w, k == len - 1);
                gap = $urandom_range(0, 2);
                if (k != len - 1 && gap != 0) begin
                    in_valid = 1'b0;
                    repeat (gap) @(negedge clk);
                end
            end
            in_valid = 1'b0;
            mx = sel ? 15 : 65535;
            check_result(raw > mx ? mx : raw, len, raw > mx, $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
